// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to stay legal.
    function automatic int cnt_w_f(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry-out and carry into its top bit.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] full_s;

    // One extra bit captures the carry-out; the top-bit carry-in is recovered from the sum.
    always_comb begin
        full_s   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
        s        = full_s[CHUNK-1:0];
        co       = full_s[CHUNK];
        c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ full_s[CHUNK-1];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_w_f(NCHUNK);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    int unsigned        base_s;
    logic [CHUNK-1:0]   a_chunk_s;
    logic [CHUNK-1:0]   b_chunk_s;
    logic [CHUNK-1:0]   s_chunk_s;
    logic               co_s;
    logic               c_msb_s;
    logic               last_s;

    // Select the operand chunk addressed by the counter.
    always_comb begin
        base_s    = 32'(cnt_q) * 32'(CHUNK);
        a_chunk_s = op_a_q[base_s +: CHUNK];
        b_chunk_s = op_b_q[base_s +: CHUNK];
        last_s    = (cnt_q == CNT_W'(NCHUNK - 1));
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a        (a_chunk_s),
        .b        (b_chunk_s),
        .ci       (cy_q),
        .s        (s_chunk_s),
        .co       (co_s),
        .c_msb_in (c_msb_s)
    );

    // Next-state logic for the FSM, operand latches, counter and results.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    // Subtraction is a + ~b + 1, so cin is replaced by the forced 1.
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    cy_d    = sub ? 1'b1 : cin;
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[base_s +: CHUNK] = s_chunk_s;
                cy_d  = co_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_s) begin
                    carry_d = co_s;
                    ovf_d   = co_s ^ c_msb_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= {WIDTH{1'b0}};
            op_b_q  <= {WIDTH{1'b0}};
            cy_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and randomized checks of seq_chunk_adder at CHUNK = 1, 4 and 16 (WIDTH = 16).
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        cin = 1'b0;

    logic [2:0]       busy_o, done_o, carry_o, ovf_o;
    logic [2:0][15:0] sum_o;

    int checks = 0;
    int failures = 0;

    // Per-instance capture from the most recent operation.
    int          lat [3];
    int          ndone [3];
    logic [15:0] res_sum [3];
    logic        res_c [3];
    logic        res_v [3];
    int          busy4;

    localparam int NCH [3] = '{16, 4, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        seq_chunk_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .sub      (sub),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .busy     (busy_o[g]),
            .done     (done_o[g]),
            .sum      (sum_o[g]),
            .carry    (carry_o[g]),
            .overflow (ovf_o[g])
        );
    end

    function automatic void ref_calc(input logic [15:0] ra, input logic [15:0] rb,
                                     input logic rsub, input logic rcin,
                                     output logic [15:0] rs, output logic rc, output logic rv);
        logic [15:0] bb;
        logic [16:0] t;
        bb = rsub ? ~rb : rb;
        t  = {1'b0, ra} + {1'b0, bb} + {16'h0000, (rsub ? 1'b1 : rcin)};
        rs = t[15:0];
        rc = t[16];
        rv = (ra[15] == bb[15]) && (t[15] != ra[15]);
    endfunction

    // Accept one operation at edge E0, then watch 40 edges; optionally pulse start mid-run.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                          input logic tcin, input bit mid_start);
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            ndone[i] = 0;
        end
        busy4 = 0;
        @(negedge clk);
        a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (mid_start && k == 1) begin
                a = 16'h1234; b = 16'h4321; sub = ~tsub; cin = ~tcin; start = 1'b1;
            end
            if (mid_start && k == 2) start = 1'b0;
            if (busy_o[1]) busy4++;
            for (int i = 0; i < 3; i++) begin
                if (done_o[i]) begin
                    ndone[i]++;
                    if (lat[i] < 0) begin
                        lat[i]     = k;
                        res_sum[i] = sum_o[i];
                        res_c[i]   = carry_o[i];
                        res_v[i]   = ovf_o[i];
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_o[i], done_o[i], sum_o[i], carry_o[i], ovf_o[i]} !== 20'h00000) begin
                failures++;
                $display("FAIL reset_state inst=%0d got busy=%b done=%b sum=%h c=%b v=%b expected all 0",
                         i, busy_o[i], done_o[i], sum_o[i], carry_o[i], ovf_o[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        run_op(16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i], res_v[i]} !== {16'h0010, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL add_basic inst=%0d got sum=%h c=%b v=%b expected sum=0010 c=0 v=0",
                         i, res_sum[i], res_c[i], res_v[i]);
            end
            checks++;
            if (lat[i] != NCH[i] || ndone[i] != 1) begin
                failures++;
                $display("FAIL add_latency inst=%0d got lat=%0d pulses=%0d expected lat=%0d pulses=1",
                         i, lat[i], ndone[i], NCH[i]);
            end
        end
        checks++;
        if (busy4 != 4) begin
            failures++;
            $display("FAIL busy_cycles got %0d expected 4", busy4);
        end
    endtask

    task automatic test_add_carry_ovf();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i], res_v[i]} !== {16'h0000, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL add_wrap inst=%0d got sum=%h c=%b v=%b expected sum=0000 c=1 v=0",
                         i, res_sum[i], res_c[i], res_v[i]);
            end
        end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i], res_v[i]} !== {16'h8000, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL add_ovf inst=%0d got sum=%h c=%b v=%b expected sum=8000 c=0 v=1",
                         i, res_sum[i], res_c[i], res_v[i]);
            end
        end
        run_op(16'h1000, 16'h0FFF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i], res_v[i]} !== {16'h2000, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL add_cin inst=%0d got sum=%h c=%b v=%b expected sum=2000 c=0 v=0",
                         i, res_sum[i], res_c[i], res_v[i]);
            end
        end
    endtask

    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i], res_v[i]} !== {16'hFFFE, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL sub_borrow inst=%0d got sum=%h c=%b v=%b expected sum=fffe c=0 v=0",
                         i, res_sum[i], res_c[i], res_v[i]);
            end
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i], res_v[i]} !== {16'h7FFF, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL sub_ovf inst=%0d got sum=%h c=%b v=%b expected sum=7fff c=1 v=1",
                         i, res_sum[i], res_c[i], res_v[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        run_op(16'h0123, 16'h0456, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_sum[i] !== 16'h0579 || lat[i] != NCH[i] || ndone[i] != 1) begin
                failures++;
                $display("FAIL start_ignored inst=%0d got sum=%h lat=%0d pulses=%0d expected sum=0579 lat=%0d pulses=1",
                         i, res_sum[i], lat[i], ndone[i], NCH[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int spurious;
        spurious = 0;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F01; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy_o[1], done_o[1], sum_o[1], carry_o[1]} !== 19'h00000) begin
            failures++;
            $display("FAIL mid_reset_state got busy=%b done=%b sum=%h c=%b expected all 0",
                     busy_o[1], done_o[1], sum_o[1], carry_o[1]);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_o != 3'b000) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL mid_reset_no_done got %0d done cycles expected 0", spurious);
        end
        run_op(16'h00FF, 16'h0F01, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_c[i]} !== {16'h1001, 1'b0} || lat[i] != NCH[i]) begin
                failures++;
                $display("FAIL after_reset inst=%0d got sum=%h c=%b lat=%0d expected sum=1001 c=0 lat=%0d",
                         i, res_sum[i], res_c[i], lat[i], NCH[i]);
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] ra, rb, es;
        logic        rs, rc, ec, ev;
        int          bad;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ref_calc(ra, rb, rs, rc, es, ec, ev);
            run_op(ra, rb, rs, rc, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({res_sum[i], res_c[i], res_v[i]} !== {es, ec, ev} || lat[i] != NCH[i]
                    || ndone[i] != 1) begin
                    failures++;
                    if (bad < 10)
                        $display("FAIL random inst=%0d a=%h b=%h sub=%b cin=%b got sum=%h c=%b v=%b lat=%0d expected sum=%h c=%b v=%b lat=%0d",
                                 i, ra, rb, rs, rc, res_sum[i], res_c[i], res_v[i], lat[i],
                                 es, ec, ev, NCH[i]);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry_ovf();
        test_sub();
        test_start_ignored();
        test_mid_reset();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
